mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: number of BUSY cycles without mem_ack_i before the arbiter aborts the access (legal range 2..255).
REQ-002 clk  input  1  single clock; every register updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 if_req_i  input  1  fetch-port request; held with if_addr_i stable until if_ack_o.
REQ-005 if_addr_i  input  32  fetch address (read only).
REQ-006 if_ack_o  output  1  one-cycle completion pulse to the fetch port.
REQ-007 if_rdata_o  output  32  fetch read data; valid only while if_ack_o=1.
REQ-008 if_err_o  output  1  fetch access aborted by timeout; pulses together with if_ack_o.
REQ-009 d_req_i  input  1  data-port (load/store) request; held with d_addr_i, d_wdata_i and d_we_i stable until d_ack_o.
REQ-010 d_addr_i  input  32  data address.
REQ-011 d_wdata_i  input  32  store data.
REQ-012 d_we_i  input  4  byte write enables; 0000 = load.
REQ-013 d_ack_o  output  1  one-cycle completion pulse to the data port.
REQ-014 d_rdata_o  output  32  load data; valid only while d_ack_o=1.
REQ-015 d_err_o  output  1  data access aborted by timeout; pulses together with d_ack_o.
REQ-016 mem_en_o  output  1  memory access enable.
REQ-017 mem_addr_o  output  32  memory address.
REQ-018 mem_wdata_o  output  32  memory write data.
REQ-019 mem_we_o  output  4  memory byte write enables.
REQ-020 mem_rdata_i  input  32  memory read data; valid while mem_ack_i=1.
REQ-021 mem_ack_i  input  1  memory completion pulse.
REQ-022 busy_o  output  1  1 whenever the state is not IDLE.

Function
REQ-023 The FSM SHALL have exactly three states: IDLE, BUSY_IF and BUSY_D.
REQ-024 In IDLE with exactly one request, the next state SHALL be the BUSY state of that port.
REQ-025 With both requests active in IDLE, the winner SHALL be chosen according to REQ-045/REQ-046.
REQ-026 In IDLE, mem_en_o, mem_we_o, and all ack and err outputs SHALL be 0.
REQ-027 In a BUSY state, mem_en_o SHALL be 1, and mem_addr_o/mem_wdata_o/mem_we_o SHALL be driven combinationally from the granted port.
REQ-028 During BUSY_IF, mem_we_o SHALL be 0000 and mem_wdata_o SHALL be 0.
REQ-029 Access latency: a request seen in IDLE at cycle N SHALL produce mem_en_o=1 at cycle N+1.
REQ-030 When mem_ack_i=1 in a BUSY state, the granted port's ack SHALL be 1 in that same cycle, with rdata = mem_rdata_i; the next state SHALL be IDLE.
REQ-031 A new grant SHALL be issued no earlier than the cycle after an ack (minimum 1 IDLE cycle between accesses).
REQ-032 rdata outputs SHALL be 0 whenever their ack is 0; the non-granted port's ack, err and rdata SHALL be 0.
REQ-033 A timeout counter SHALL clear on entry to a BUSY state and increment on every BUSY cycle without mem_ack_i.
REQ-034 Timeout abort: when the counter equals TIMEOUT-1 and mem_ack_i=0, the arbiter SHALL pulse ack and err of the granted port with rdata=0, then return to IDLE.
REQ-035 If mem_ack_i=1 in the timeout cycle, the access SHALL complete normally with err=0.
REQ-036 mem_ack_i in IDLE SHALL be ignored.
REQ-037 A request deasserted before its ack is a protocol violation; the arbiter SHALL complete the granted access regardless and SHALL never change the grant mid-access.
REQ-038 busy_o SHALL equal (state != IDLE).

Reset
REQ-039 While rst_i=1 at a clock edge: state SHALL become IDLE, the timeout counter 0, and the last-grant register "fetch".
REQ-040 All outputs SHALL be 0 in the cycle after reset.
REQ-041 Reset asserted mid-access SHALL abort the access with no ack or err pulse to either port.
REQ-042 The first arbitration decision SHALL be the cycle after rst_i deasserts.

Configuration
REQ-043 Macro ARB_ROUND_ROBIN_EN SHALL select the simultaneous-request policy.
REQ-044 A last-grant register SHALL update on every grant.
REQ-045 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port NOT granted last.
REQ-046 Without ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always go to the data port; the last-grant register is then unused.

Verification
REQ-047 Fetch-only read: if_req_i=1, addr=0x0000_0100, memory acks 3 cycles after mem_en_o with 0xDEAD_BEEF -> mem_en_o at N+1, if_ack_o pulse with if_rdata_o=0xDEAD_BEEF, then IDLE.
REQ-048 Store: d_req_i=1, addr=0x0000_2000, wdata=0x1234_5678, we=1111 -> mem_we_o=1111, mem_wdata_o=0x1234_5678, single d_ack_o pulse, if_ack_o stays 0.
REQ-049 Both ports held requesting for 4 accesses -> grant order D,IF,D,IF with ARB_ROUND_ROBIN_EN; D,D,D,D without it.
REQ-050 No mem_ack_i, TIMEOUT=4 -> d_ack_o=d_err_o=1 exactly 4 cycles after entering BUSY_D, d_rdata_o=0; mem_ack_i arriving in cycle 4 instead -> err=0.
REQ-051 rst_i=1 during BUSY_IF, then mem_ack_i=1 -> no if_ack_o or if_err_o pulse, busy_o=0 next cycle, next grant follows fetch-last policy.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) memory arbiter with per-access timeout abort; ARB_ROUND_ROBIN_EN selects
// round-robin instead of data-first priority on simultaneous requests. Grant 1 cycle after request.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_we_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        mem_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_we_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] tmo_cnt;
  logic       grant_d;
  logic       timeout;
  logic       done;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  assign grant_d = d_req_i & (~if_req_i | ~last_d);
`else
  assign grant_d = d_req_i;
`endif

  assign timeout = (state != IDLE) && !mem_ack_i && (tmo_cnt == TMO_LAST);
  // Reset in the completion cycle suppresses the pulse: the access is abandoned, not finished.
  assign done    = (state != IDLE) && (mem_ack_i || timeout) && !rst_i;
  assign busy_o  = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)       state_nxt = BUSY_D;
        else if (if_req_i) state_nxt = BUSY_IF;
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ack_i || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state   <= IDLE;
      tmo_cnt <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE)  tmo_cnt <= 8'd0;
      else if (!mem_ack_i) tmo_cnt <= tmo_cnt + 8'd1;
`ifdef ARB_ROUND_ROBIN_EN
      if (state == IDLE && state_nxt != IDLE) last_d <= (state_nxt == BUSY_D);
`endif
    end
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = '0;
    if_ack_o    = 1'b0;
    if_err_o    = 1'b0;
    if_rdata_o  = '0;
    d_ack_o     = 1'b0;
    d_err_o     = 1'b0;
    d_rdata_o   = '0;
    case (state)
      BUSY_IF: begin
        mem_en_o   = 1'b1;
        mem_addr_o = if_addr_i;
        if (done) begin
          if_ack_o   = 1'b1;
          if_err_o   = timeout;
          if_rdata_o = mem_ack_i ? mem_rdata_i : '0;
        end
      end
      BUSY_D: begin
        mem_en_o    = 1'b1;
        mem_addr_o  = d_addr_i;
        mem_wdata_o = d_wdata_i;
        mem_we_o    = d_we_i;
        if (done) begin
          d_ack_o   = 1'b1;
          d_err_o   = timeout;
          d_rdata_o = mem_ack_i ? mem_rdata_i : '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, directed scenarios, then random traffic.
module tb_mem_arbiter;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;
  logic        d_req_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_we_i;
  logic        d_ack_o;
  logic [31:0] d_rdata_o;
  logic        d_err_o;
  logic        mem_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        busy_o;

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o),
    .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_we_i(d_we_i),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: which port owns memory (0 none, 1 fetch, 2 data) and how many BUSY cycles it has lasted.
  int m_port = 0;
  int m_age = 0;
  int lat_cur = 0;
  int lat_sel = 1;
  int done_port = 0;
  bit force_ack = 1'b0;
  int ackq[$];
`ifdef ARB_ROUND_ROBIN_EN
  bit m_last_d = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: memory response is chosen from the model, outputs checked at the falling edge.
  task automatic cycle();
    bit ack_now, done;
    int pick;
    logic [31:0] rd;
    ack_now = force_ack || (m_port != 0 && m_age == lat_cur);
    rd = $urandom;
    mem_ack_i = ack_now;
    mem_rdata_i = rd;
    @(negedge clk);
    done = (m_port != 0) && !rst_i && (ack_now || m_age == TMO);
    chk("busy",      32'(busy_o),    32'(m_port != 0));
    chk("mem_en",    32'(mem_en_o),  32'(m_port != 0));
    chk("mem_addr",  mem_addr_o,     m_port == 1 ? if_addr_i : (m_port == 2 ? d_addr_i : 32'h0));
    chk("mem_wdata", mem_wdata_o,    m_port == 2 ? d_wdata_i : 32'h0);
    chk("mem_we",    32'(mem_we_o),  m_port == 2 ? 32'(d_we_i) : 32'h0);
    chk("if_ack",    32'(if_ack_o),  32'(done && m_port == 1));
    chk("if_err",    32'(if_err_o),  32'(done && m_port == 1 && !ack_now));
    chk("if_rdata",  if_rdata_o,     (done && m_port == 1 && ack_now) ? rd : 32'h0);
    chk("d_ack",     32'(d_ack_o),   32'(done && m_port == 2));
    chk("d_err",     32'(d_err_o),   32'(done && m_port == 2 && !ack_now));
    chk("d_rdata",   d_rdata_o,      (done && m_port == 2 && ack_now) ? rd : 32'h0);
    if (d_ack_o === 1'b1) ackq.push_back(2);
    else if (if_ack_o === 1'b1) ackq.push_back(1);
    done_port = done ? m_port : 0;
    if (rst_i) begin
      m_port = 0;
      m_age = 0;
`ifdef ARB_ROUND_ROBIN_EN
      m_last_d = 1'b0;
`endif
    end else if (m_port == 0) begin
      if (if_req_i || d_req_i) begin
        pick = d_req_i ? 2 : 1;
`ifdef ARB_ROUND_ROBIN_EN
        if (if_req_i && d_req_i) pick = m_last_d ? 1 : 2;
        m_last_d = (pick == 2);
`endif
        m_port = pick;
        m_age = 1;
        lat_cur = (lat_sel < 0) ? int'($urandom_range(0, 5)) : lat_sel;
      end
    end else if (done) begin
      m_port = 0;
      m_age = 0;
    end else begin
      m_age++;
    end
    @(posedge clk);
    #1;
  endtask

  // Run until n accesses complete; lat=0 never acks, lat<0 picks a random latency per access.
  task automatic serve(input int n, input int lat, input bit hold);
    int got = 0;
    int budget = 0;
    lat_sel = lat;
    while (got < n && budget < 80) begin
      cycle();
      budget++;
      if (done_port != 0) begin
        got++;
        if (!hold && done_port == 1) if_req_i = 1'b0;
        if (!hold && done_port == 2) d_req_i = 1'b0;
      end
    end
    chk("serve_done", got, n);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cycle();
    cycle();
    rst_i = 1'b0;
  endtask

  initial begin
    int exp_order[4];
    rst_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_we_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    do_reset();

    // Stray memory ack while idle must be ignored.
    force_ack = 1'b1;
    cycle();
    force_ack = 1'b0;
    cycle();

    // Fetch read, data returned on third BUSY cycle.
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    ackq.delete();
    serve(1, 3, 1'b0);
    chk("fetch_ack_port", ackq.size() > 0 ? 32'(ackq[0]) : 32'h0, 32'd1);
    cycle();

    // Full-word store.
    d_req_i = 1'b1; d_addr_i = 32'h0000_2000; d_wdata_i = 32'h1234_5678; d_we_i = 4'b1111;
    ackq.delete();
    serve(1, 2, 1'b0);
    chk("store_ack_cnt", ackq.size(), 1);
    cycle();

    // Both ports held for four accesses from a fresh reset.
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h0000_0400;
    d_req_i = 1'b1; d_addr_i = 32'h0000_3000; d_we_i = 4'b0000;
    ackq.delete();
    serve(4, -1, 1'b1);
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{2, 1, 2, 1};
`else
    exp_order = '{2, 2, 2, 2};
`endif
    chk("order_len", ackq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("order", i < ackq.size() ? 32'(ackq[i]) : 32'h0, 32'(exp_order[i]));
    if_req_i = 1'b0; d_req_i = 1'b0;
    cycle();

    // Timeout abort on a load, then ack exactly in the timeout cycle.
    d_req_i = 1'b1; d_addr_i = 32'h0000_5000;
    serve(1, 0, 1'b0);
    cycle();
    d_req_i = 1'b1;
    serve(1, TMO, 1'b0);
    cycle();

    // Reset during a fetch access with a memory ack in the same cycle.
    if_req_i = 1'b1; if_addr_i = 32'h0000_0800;
    lat_sel = 0;
    cycle(); cycle(); cycle();
    rst_i = 1'b1; force_ack = 1'b1;
    cycle();
    rst_i = 1'b0; d_req_i = 1'b1; d_addr_i = 32'h0000_6000;
    ackq.delete();
    cycle();
    force_ack = 1'b0;
    serve(2, 2, 1'b0);
    chk("post_rst_first", ackq.size() > 0 ? 32'(ackq[0]) : 32'h0, 32'd2);
    chk("post_rst_cnt", ackq.size(), 2);

    // Random traffic.
    for (int k = 0; k < 60; k++) begin
      if (!if_req_i && $urandom_range(0, 1) == 1) begin
        if_req_i = 1'b1; if_addr_i = $urandom;
      end
      if (!d_req_i && ($urandom_range(0, 1) == 1 || !if_req_i)) begin
        d_req_i = 1'b1; d_addr_i = $urandom; d_wdata_i = $urandom;
        d_we_i = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      end
      serve(1, -1, 1'b0);
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    cycle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
